pwm_generator: RTL and testbench
================================

Name: pwm_generator

Overview:
- Consumer end of the controller's 8-bit duty output; converts the defuzzified duty word into a physical PWM waveform for the drive stage.
- Duty updates arrive asynchronously to the PWM period. They are double-buffered and applied only at a period boundary, so every pulse is glitch-free.
- Has a prescaled tick, a 256-step period counter and an enable FSM with graceful stop.

Parameters:
- PRESCALE, 1, clk cycles per PWM tick (>=1); PWM period = 256*PRESCALE clk cycles.
- DUTY_W, 8, duty word width; fixed at 8 for this block.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- duty  input  8  requested duty; high time = duty/256 of the period.
- duty_valid  input  1  sample duty this cycle; the latest value wins.
- enable  input  1  run request (level).
- pwm_out  output  1  registered PWM output.
- period_start  output  1  one-cycle pulse when a new period begins.
- duty_ack  output  1  one-cycle pulse when a new duty is loaded into the active register.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - pwm_out=0, period_start=0, duty_ack=0, busy=0.
  - state=IDLE, cnt=0, presc=0, shadow=0, pending=0, pend_flag=0.
- Pending capture:
  - duty_valid=1 -> pending<=duty, pend_flag<=1.
  - Captured in every state.
- Load value:
  - If duty_valid=1 in the loading cycle, the live duty is used (bypass). Otherwise pending is used.
  - A load happens only if duty_valid or pend_flag is set. It clears pend_flag and pulses duty_ack on the next cycle.
- Tick:
  - presc counts 0..PRESCALE-1 while state != IDLE.
  - tick = (presc==PRESCALE-1); presc wraps to 0.
  - presc is held at 0 in IDLE.
  - PRESCALE=1 -> tick every cycle.
- Boundary: tick && cnt==255.
- FSM (states IDLE, RUN, STOP):
  - IDLE, enable=1 -> RUN. Same edge: cnt<=0, presc<=0, shadow load if available, period_start pulses next cycle.
  - RUN: cnt increments on each tick, wrapping 255->0.
    - At a boundary: shadow load if available, period_start pulse.
    - enable=0 -> STOP. The current period is not cut short.
  - STOP: counting continues.
    - enable=1 -> RUN with no discontinuity in cnt or pwm_out.
    - Boundary with enable=0 -> IDLE, cnt<=0. No period_start pulse and no shadow load.
  - Boundary with enable=0 in RUN: treated as the transition to STOP first; the period ends at the next boundary.
- Output:
  - pwm_out <= (state!=IDLE) && (cnt < shadow); one-cycle latency after cnt.
  - duty=0 -> constantly low.
  - duty=255 -> high 255 ticks, low 1 tick per period. 100% is not representable, by design.
- Simultaneous duty_valid and boundary: the new value takes effect in the period that starts at that boundary; duty_ack fires once.
- Multiple duty_valid pulses within one period: only the last is applied; duty_ack fires once per boundary.
- Reset mid-operation: all outputs go to reset values immediately and asynchronously. After release, the block waits in IDLE until enable.

Decomposition:
- fuzzy_pkg holds:
  - pwm_state_t enum (IDLE, RUN, STOP);
  - DUTY_W=8;
  - PWM_STEPS=256;
  - CNT_MAX=8'd255.
- One sub-module: pwm_prescaler.
  - Inputs: clk, rst_n, run.
  - Output: tick.
  - Parameter: PRESCALE.
  - When run=0 it clears its counter.

Test Plan:
- Enable path, PRESCALE=1: reset, duty=64 with duty_valid, enable=1 -> first period_start 1 cycle later; pwm_out high 64 cycles, low 192; period_start every 256 cycles; duty_ack exactly once.
- Extremes: duty=0 -> pwm_out never high over 3 periods. duty=255 -> high 255, low 1 each period.
- Mid-period update: running at 64, apply duty=192 when cnt=100 -> current period stays 64 high; next period 192 high; duty_ack pulses at that boundary only. Updates 10/20/30 within one period -> next period is 30 high.
- Graceful stop: enable=0 at cnt=10 -> period completes, then pwm_out=0, busy=0, cnt=0, no extra period_start. Second run: re-assert enable at cnt=200 during STOP -> waveform continues unbroken.
- Prescale: PRESCALE=4, duty=64 -> period 1024 cycles, high 256 cycles; period_start spacing 1024.
- Async reset: assert rst_n=0 while pwm_out=1 -> pwm_out=0 before the next clk edge. After release, idle until enable; shadow=0, so the first period is low unless duty_valid is given.

Source files
------------

// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the PWM output stage.
package fuzzy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pwm_state_t;

  localparam int          DUTY_W    = 8;
  localparam int          PWM_STEPS = 256;
  localparam logic [7:0]  CNT_MAX   = 8'd255;

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk down to one PWM tick every PRESCALE cycles while running.
module pwm_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  // A one-bit counter still works for PRESCALE=1: it stays at 0 and ticks every cycle.
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = run && (presc_q == LAST);

  // Next count: cleared while stopped, wraps after the last step.
  always_comb begin
    presc_d = presc_q;
    if (!run)      presc_d = '0;
    else if (tick) presc_d = '0;
    else           presc_d = presc_q + 1'b1;
  end

  // Prescale counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

endmodule

// File: rtl/pwm_generator.sv
// 256-step PWM with double-buffered duty, applied only at period boundaries,
// and an enable FSM that always finishes the running period before idling.
module pwm_generator
  import fuzzy_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int DUTY_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty,
  input  logic              duty_valid,
  input  logic              enable,
  output logic              pwm_out,
  output logic              period_start,
  output logic              duty_ack,
  output logic              busy
);

  pwm_state_t        state_q, state_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] shadow_q, pending_q;
  logic              pend_flag_q;
  logic              pwm_q, pwm_d;
  logic              pstart_q, pstart_d;
  logic              ack_q;
  logic              do_load;
  logic              tick, boundary;
  logic              load_avail;
  logic [DUTY_W-1:0] load_val;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_q != IDLE),
    .tick  (tick)
  );

  assign boundary   = tick && (cnt_q == CNT_MAX);
  // A duty word arriving in the load cycle itself bypasses the pending register.
  assign load_avail = duty_valid || pend_flag_q;
  assign load_val   = duty_valid ? duty : pending_q;

  // Next-state, counter and boundary actions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_load  = 1'b0;
    pstart_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = RUN;
          cnt_d    = '0;
          do_load  = load_avail;
          pstart_d = 1'b1;
        end
      end
      RUN: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        if (boundary) begin
          do_load  = load_avail;
          pstart_d = 1'b1;
        end
        // Dropping enable only arms the stop; the period in flight runs out.
        if (!enable) state_d = STOP;
      end
      STOP: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        if (enable) begin
          state_d = RUN;
          if (boundary) begin
            do_load  = load_avail;
            pstart_d = 1'b1;
          end
        end else if (boundary) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Compare is against the active (shadow) duty only, so a pulse never glitches.
  assign pwm_d = (state_q != IDLE) && (cnt_q < shadow_q);

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pwm_q    <= 1'b0;
      pstart_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      pstart_q <= pstart_d;
      ack_q    <= do_load;
    end
  end

  // Duty double buffer: pending captures every request, shadow takes it at a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
      shadow_q    <= '0;
    end else begin
      if (duty_valid) begin
        pending_q   <= duty;
        pend_flag_q <= 1'b1;
      end
      if (do_load) begin
        shadow_q    <= load_val;
        pend_flag_q <= 1'b0;
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = pstart_q;
  assign duty_ack     = ack_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_generator.sv
// Period-level scoreboard for pwm_generator: each stimulus phase pushes the
// expected (length, high-time) of the periods it should produce; a monitor
// measures every completed period and pops/compares.
module tb_pwm_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] duty;
  logic       duty_valid;
  logic       enable, en4;
  logic       pwm1, ps1, ack1, busy1;
  logic       pwm4, ps4, ack4, busy4;
  logic       sel;

  always #5 clk = ~clk;

  pwm_generator #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .duty(duty), .duty_valid(duty_valid),
    .enable(enable), .pwm_out(pwm1), .period_start(ps1),
    .duty_ack(ack1), .busy(busy1)
  );

  pwm_generator #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .duty(duty), .duty_valid(duty_valid),
    .enable(en4), .pwm_out(pwm4), .period_start(ps4),
    .duty_ack(ack4), .busy(busy4)
  );

  wire m_pwm  = sel ? pwm4  : pwm1;
  wire m_ps   = sel ? ps4   : ps1;
  wire m_ack  = sel ? ack4  : ack1;
  wire m_busy = sel ? busy4 : busy1;

  typedef struct { int len; int hi; } per_t;
  per_t exp_q[$];

  int n_chk = 0, n_err = 0;
  int ack_cnt = 0, ps_cnt = 0;
  int len = 0, hi = 0;
  bit in_per = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input int l, input int h, input int n);
    per_t e;
    e.len = l; e.hi = h;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic finalize();
    per_t e;
    if (exp_q.size() == 0) chk("unexpected_period", len, 0);
    else begin
      e = exp_q.pop_front();
      chk("period_len", len, e.len);
      chk("period_high", hi, e.hi);
    end
  endtask

  // Monitor: a period's pwm lags its period_start by one cycle, so the sample
  // that shows the next period_start (or busy falling) still belongs to it.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_per = 0; len = 0; hi = 0;
    end else begin
      if (m_ack) ack_cnt++;
      if (m_ps)  ps_cnt++;
      if (in_per) hi += int'(m_pwm);
      if (m_ps) begin
        if (in_per) finalize();
        in_per = 1; len = 0; hi = 0;
      end else if (in_per && !m_busy) begin
        finalize();
        in_per = 0;
      end
      if (in_per) len++;
    end
  end

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("scoreboard_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!m_ps && n < 2000);
    if (!m_ps) chk("period_start_timeout", 0, 1);
  endtask

  task automatic drive_duty(input logic [7:0] v);
    duty = v; duty_valid = 1'b1;
    @(negedge clk); #1;
    duty_valid = 1'b0;
  endtask

  int a0, p0;

  initial begin
    rst_n = 1'b0; duty = '0; duty_valid = 1'b0; enable = 1'b0; en4 = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm1, 0);
    chk("rst_pstart", ps1, 0);
    chk("rst_ack", ack1, 0);
    chk("rst_busy", busy1, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk); #1;

    // Enable with duty 64: period_start and ack one cycle later.
    a0 = ack_cnt;
    push(256, 64, 2);
    enable = 1'b1;
    drive_duty(8'd64);
    chk("first_pstart", ps1, 1);
    chk("first_ack", ack1, 1);
    chk("busy_run", busy1, 1);
    wait_empty();
    chk("ack_once_64", ack_cnt - a0, 1);

    // duty 0 takes effect next period, low for three periods.
    a0 = ack_cnt;
    push(256, 64, 1); push(256, 0, 3);
    drive_duty(8'd0);
    wait_empty();
    chk("ack_once_0", ack_cnt - a0, 1);

    // duty 255: high 255, low 1.
    push(256, 0, 1); push(256, 255, 2);
    drive_duty(8'd255);
    wait_empty();

    // Back to 64, then a mid-period update to 192 at cnt~100.
    push(256, 255, 1); push(256, 64, 1);
    drive_duty(8'd64);
    wait_empty();
    a0 = ack_cnt;
    push(256, 64, 1); push(256, 192, 1);
    repeat (100) @(negedge clk);
    #1 drive_duty(8'd192);
    wait_empty();
    chk("ack_mid_update", ack_cnt - a0, 1);

    // Several updates in one period: only the last applies.
    a0 = ack_cnt;
    push(256, 192, 1); push(256, 30, 1);
    drive_duty(8'd10);
    repeat (20) @(negedge clk);
    #1 drive_duty(8'd20);
    repeat (20) @(negedge clk);
    #1 drive_duty(8'd30);
    wait_empty();
    chk("ack_last_wins", ack_cnt - a0, 1);

    // Graceful stop at cnt~10: the 30-period completes, then idle.
    push(256, 30, 1);
    repeat (10) @(negedge clk);
    #1 enable = 1'b0;
    wait_empty();
    p0 = ps_cnt;
    repeat (300) @(negedge clk);
    chk("stop_busy", busy1, 0);
    chk("stop_pwm", pwm1, 0);
    chk("stop_cnt", int'(dut1.cnt_q), 0);
    chk("stop_no_pstart", ps_cnt - p0, 0);

    // Second run: drop enable, re-assert during STOP at cnt~200, no break.
    a0 = ack_cnt; p0 = ps_cnt;
    push(256, 30, 2);
    #1 enable = 1'b1;
    wait_ps();
    repeat (10) @(negedge clk);
    #1 enable = 1'b0;
    repeat (190) @(negedge clk);
    #1 enable = 1'b1;
    wait_empty();
    push(256, 30, 1);
    enable = 1'b0;
    wait_empty();
    chk("rerun_pstarts", ps_cnt - p0, 3);
    chk("rerun_no_ack", ack_cnt - a0, 0);

    // Async reset while pwm is high.
    enable = 1'b1;
    drive_duty(8'd200);
    repeat (50) @(negedge clk);
    chk("pre_reset_pwm", pwm1, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", pwm1, 0);
    chk("async_rst_busy", busy1, 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", busy1, 0);
    chk("post_rst_shadow", int'(dut1.shadow_q), 0);
    #1;
    push(256, 0, 1);
    enable = 1'b1;
    wait_empty();
    push(256, 0, 1);
    enable = 1'b0;
    wait_empty();

    // PRESCALE=4 instance: 1024-cycle periods, 256 cycles high.
    @(negedge clk); #1;
    sel = 1'b1;
    a0 = ack_cnt;
    push(1024, 256, 2);
    en4 = 1'b1;
    drive_duty(8'd64);
    wait_empty();
    push(1024, 256, 1);
    en4 = 1'b0;
    wait_empty();
    chk("presc_ack", ack_cnt - a0, 1);
    repeat (5) @(negedge clk);
    chk("presc_idle", busy4, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
